lru_tracker_param: RTL and testbench
====================================

LRU_TRACKER_PARAM -- requirements
Module: lru_tracker_param

Interface
REQ-001 SHALL have parameter WAYS, default 4: number of tracked ways (2..16).
REQ-002 SHALL have parameter AGE_W, default 3: width of each per-way age register (2..8).
REQ-003 SHALL have parameter AGE_PERIOD, default 16: number of hit-accesses per aging step (power of two, 2..256).
REQ-004 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port access_en, input, 1: a read access occurs this cycle.
REQ-007 SHALL have port hit_way, input, WAYS: per-way hit flags; valid only with access_en.
REQ-008 SHALL have port inv_en, input, 1: invalidate request this cycle.
REQ-009 SHALL have port inv_way, input, WAYS: ways to invalidate; valid only with inv_en.
REQ-010 SHALL have port lock_mask, input, WAYS: a 1 excludes that way from victim selection; sampled at request.
REQ-011 SHALL have port victim_req, input, 1: start a victim search.
REQ-012 SHALL have port busy, output, 1: a search is in progress.
REQ-013 SHALL have port victim_valid, output, 1: one-cycle pulse when a result is ready.
REQ-014 SHALL have port victim_way, output, WAYS: one-hot victim; held until the next result.
REQ-015 SHALL have port victim_idx, output, clog2(WAYS): binary victim index; held until the next result.
REQ-016 SHALL have port victim_none, output, 1: all ways were locked; held with the result.

Function
REQ-017 SHALL keep one AGE_W-bit age register per way; a higher value means more recently used.
REQ-018 SHALL keep an access timer of clog2(AGE_PERIOD) bits that increments on access_en with any hit_way bit set, and SHALL wrap from AGE_PERIOD-1 to 0.
- Accesses with hit_way all zero SHALL leave the timer unchanged.
REQ-019 On access_en with timer==0, each age SHALL become (age>>1) OR (hit_way[i] in the MSB).
REQ-020 On access_en with timer!=0, each age SHALL become age OR (hit_way[i] in the MSB).
REQ-021 On inv_en, the age of each way with inv_way[i]=1 SHALL become 0.
- Invalidate SHALL take priority over a same-cycle access on that way.
- inv_en SHALL NOT change the timer.
REQ-022 The search FSM SHALL have states IDLE, SCAN and DONE.
- IDLE -> SCAN: on victim_req; the FSM SHALL snapshot all ages and lock_mask.
- SCAN: SHALL examine one way per cycle, index 0 to WAYS-1, and SHALL track the minimum age among unlocked ways.
- SCAN -> DONE: after way WAYS-1 has been examined.
- DONE -> IDLE: unconditionally; victim_valid SHALL be 1 in DONE.
REQ-023 Latency: with victim_req high at edge T, victim_valid SHALL be high in the cycle after edge T+WAYS+1.
REQ-024 Ties SHALL resolve to the lowest index; strict less-than comparison only.
REQ-025 If every way is locked, the result SHALL be victim_none=1, victim_way=0 and victim_idx=0.
REQ-026 busy SHALL be high in SCAN and DONE.
- victim_req while busy SHALL be ignored and SHALL NOT be queued.
REQ-027 Ages SHALL keep updating during a search; the result SHALL reflect the snapshot only.
REQ-028 victim_way SHALL equal the one-hot decode of victim_idx whenever victim_none=0.

Reset
REQ-029 On rst, all ages, the timer, busy, victim_valid, victim_none, victim_way and victim_idx SHALL be 0, and the FSM SHALL be in IDLE.
REQ-030 rst during SCAN or DONE SHALL abort the search with no victim_valid pulse.
REQ-031 rst SHALL override same-cycle access_en, inv_en and victim_req.

Verification (WAYS=4, AGE_W=3, AGE_PERIOD=16)
REQ-032 Reset, then victim_req -> busy for 5 cycles, then victim_valid pulse with victim_idx=0, victim_way=0001, victim_none=0.
REQ-033 Three accesses hitting 0001, 0010, 0100 (timer 0,1,2) -> ages 100,100,100,000; victim_req -> victim_idx=3.
REQ-034 Same state with lock_mask=1000 -> victim_idx=0 (three-way tie resolves to lowest index); lock_mask=1111 -> victim_none=1, victim_way=0000.
REQ-035 16 accesses hitting 0001, then a 17th hitting 0010 -> age0=010, age1=100, timer=1; victim_req -> victim_idx=2.
REQ-036 Simultaneous access hit 0001 and inv_way 0001 -> age0=000; timer still increments to 1.
REQ-037 victim_req, rst asserted 2 cycles later, then hits on 0001 during the search -> no victim_valid pulse, busy=0 the cycle after reset; a separate search with hits during SCAN -> result matches the pre-request snapshot.

Source files
------------

// File: rtl/lru_tracker_param.sv
// Age-based LRU tracker: per-way aging registers plus a sequential victim search.
// Search latency WAYS+2 cycles from request to victim_valid; requests while busy are dropped.
module lru_tracker_param #(
    parameter int WAYS       = 4,
    parameter int AGE_W      = 3,
    parameter int AGE_PERIOD = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     access_en,
    input  logic [WAYS-1:0]          hit_way,
    input  logic                     inv_en,
    input  logic [WAYS-1:0]          inv_way,
    input  logic [WAYS-1:0]          lock_mask,
    input  logic                     victim_req,
    output logic                     busy,
    output logic                     victim_valid,
    output logic [WAYS-1:0]          victim_way,
    output logic [$clog2(WAYS)-1:0]  victim_idx,
    output logic                     victim_none
);

    localparam int IDX_W = $clog2(WAYS);
    localparam int TMR_W = $clog2(AGE_PERIOD);
    localparam int CNT_W = $clog2(WAYS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAYS);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(AGE_PERIOD - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t state_q, state_d;

    logic [AGE_W-1:0] age_q      [WAYS];
    logic [AGE_W-1:0] age_d      [WAYS];
    logic [AGE_W-1:0] snap_age_q [WAYS];
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [WAYS-1:0]  snap_lock_q;
    logic [CNT_W-1:0] cnt_q;
    logic             found_q;
    logic [AGE_W-1:0] best_age_q;
    logic [IDX_W-1:0] best_idx_q;

    logic [WAYS-1:0]  victim_way_q, victim_way_d;
    logic [IDX_W-1:0] victim_idx_q, victim_idx_d;
    logic             victim_none_q, victim_none_d;

    logic             scan_last;
    logic [IDX_W-1:0] scan_idx;
    logic             take_way;

    // Aging: periodic right shift halves history; invalidate wins over a same-cycle hit.
    always_comb begin
        timer_d = timer_q;
        for (int i = 0; i < WAYS; i++) begin
            age_d[i] = age_q[i];
        end
        if (access_en) begin
            for (int i = 0; i < WAYS; i++) begin
                if (timer_q == '0) begin
                    age_d[i] = {hit_way[i], age_q[i][AGE_W-1:1]};
                end else begin
                    age_d[i] = age_q[i] | {hit_way[i], {(AGE_W-1){1'b0}}};
                end
            end
            if (|hit_way) begin
                timer_d = (timer_q == TMR_MAX) ? '0 : timer_q + TMR_W'(1);
            end
        end
        if (inv_en) begin
            for (int i = 0; i < WAYS; i++) begin
                if (inv_way[i]) begin
                    age_d[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
            for (int i = 0; i < WAYS; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            timer_q <= timer_d;
            for (int i = 0; i < WAYS; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    assign scan_last = (cnt_q == LAST_CNT);
    assign scan_idx  = cnt_q[IDX_W-1:0];

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        take_way = 1'b0;
        if (!scan_last && !snap_lock_q[scan_idx]) begin
            take_way = !found_q || (snap_age_q[scan_idx] < best_age_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (victim_req) state_d = S_SCAN;
            S_SCAN:  if (scan_last)  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q != S_IDLE);
        victim_valid = (state_q == S_DONE);
    end

    always_comb begin
        victim_way_d  = victim_way_q;
        victim_idx_d  = victim_idx_q;
        victim_none_d = victim_none_q;
        if (state_q == S_SCAN && scan_last) begin
            victim_none_d = !found_q;
            victim_idx_d  = found_q ? best_idx_q : '0;
            victim_way_d  = '0;
            if (found_q) begin
                victim_way_d[best_idx_q] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_lock_q   <= '0;
            cnt_q         <= '0;
            found_q       <= 1'b0;
            best_age_q    <= '0;
            best_idx_q    <= '0;
            victim_way_q  <= '0;
            victim_idx_q  <= '0;
            victim_none_q <= 1'b0;
            for (int i = 0; i < WAYS; i++) begin
                snap_age_q[i] <= '0;
            end
        end else begin
            victim_way_q  <= victim_way_d;
            victim_idx_q  <= victim_idx_d;
            victim_none_q <= victim_none_d;
            if (state_q == S_IDLE && victim_req) begin
                snap_lock_q <= lock_mask;
                cnt_q       <= '0;
                found_q     <= 1'b0;
                for (int i = 0; i < WAYS; i++) begin
                    snap_age_q[i] <= age_q[i];
                end
            end else if (state_q == S_SCAN && !scan_last) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (take_way) begin
                    found_q    <= 1'b1;
                    best_age_q <= snap_age_q[scan_idx];
                    best_idx_q <= scan_idx;
                end
            end
        end
    end

    assign victim_way  = victim_way_q;
    assign victim_idx  = victim_idx_q;
    assign victim_none = victim_none_q;

endmodule

// File: tb/tb_lru_tracker_param.sv
// Directed bench for lru_tracker_param at WAYS=4, AGE_W=3, AGE_PERIOD=16.
module tb_lru_tracker_param;

    logic       clk;
    logic       rst;
    logic       access_en;
    logic [3:0] hit_way;
    logic       inv_en;
    logic [3:0] inv_way;
    logic [3:0] lock_mask;
    logic       victim_req;
    logic       busy;
    logic       victim_valid;
    logic [3:0] victim_way;
    logic [1:0] victim_idx;
    logic       victim_none;

    int checks = 0;
    int errors = 0;

    lru_tracker_param #(.WAYS(4), .AGE_W(3), .AGE_PERIOD(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .access_en    (access_en),
        .hit_way      (hit_way),
        .inv_en       (inv_en),
        .inv_way      (inv_way),
        .lock_mask    (lock_mask),
        .victim_req   (victim_req),
        .busy         (busy),
        .victim_valid (victim_valid),
        .victim_way   (victim_way),
        .victim_idx   (victim_idx),
        .victim_none  (victim_none)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reset with access/victim_req asserted alongside, which reset must override.
    task automatic do_reset();
        rst        = 1'b1;
        access_en  = 1'b1;
        hit_way    = 4'b0001;
        victim_req = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        access_en  = 1'b0;
        hit_way    = 4'b0000;
        victim_req = 1'b0;
    endtask

    task automatic access(input logic [3:0] hit, input int reps);
        for (int r = 0; r < reps; r++) begin
            access_en = 1'b1;
            hit_way   = hit;
            @(negedge clk);
        end
        access_en = 1'b0;
        hit_way   = 4'b0000;
    endtask

    // traffic=1 hits way 3, invalidates way 0 and re-requests while the scan runs.
    task automatic do_search(input string tag, input logic [3:0] lock, input int exp_idx,
                             input bit exp_none, input bit traffic);
        int n;
        logic [3:0] exp_way;
        exp_way    = exp_none ? 4'b0000 : (4'b0001 << exp_idx);
        lock_mask  = lock;
        victim_req = 1'b1;
        @(negedge clk);
        victim_req = 1'b0;
        lock_mask  = 4'b0000;
        chk({tag, "_busy"}, busy, 1);
        if (traffic) begin
            access_en  = 1'b1;
            hit_way    = 4'b1000;
            inv_en     = 1'b1;
            inv_way    = 4'b0001;
            victim_req = 1'b1;
        end
        n = 1;
        while (!victim_valid && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 3) begin
                access_en  = 1'b0;
                hit_way    = 4'b0000;
                inv_en     = 1'b0;
                inv_way    = 4'b0000;
                victim_req = 1'b0;
            end
        end
        chk({tag, "_lat"}, n, 6);
        chk({tag, "_idx"}, victim_idx, exp_idx);
        chk({tag, "_way"}, victim_way, exp_way);
        chk({tag, "_none"}, victim_none, exp_none);
        @(negedge clk);
        chk({tag, "_end"}, {busy, victim_valid}, 2'b00);
        chk({tag, "_hold"}, victim_idx, exp_idx);
    endtask

    initial begin
        bit saw_valid;
        rst        = 1'b1;
        access_en  = 1'b0;
        hit_way    = 4'b0000;
        inv_en     = 1'b0;
        inv_way    = 4'b0000;
        lock_mask  = 4'b0000;
        victim_req = 1'b0;
        @(negedge clk);
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_valid", victim_valid, 0);
        chk("rst_way", victim_way, 0);
        chk("rst_idx", victim_idx, 0);
        chk("rst_none", victim_none, 0);

        do_search("fresh", 4'b0000, 0, 1'b0, 1'b0);

        // ages 100,100,100,000 after hits at timer 0,1,2
        do_reset();
        access(4'b0001, 1);
        access(4'b0010, 1);
        access(4'b0100, 1);
        do_search("three", 4'b0000, 3, 1'b0, 1'b0);
        do_search("lock3", 4'b1000, 0, 1'b0, 1'b0);
        do_search("lockall", 4'b1111, 0, 1'b1, 1'b0);
        do_search("snap", 4'b0000, 3, 1'b0, 1'b1);
        // way 0 invalidated, way 3 hit during the previous scan
        do_search("after_snap", 4'b0000, 0, 1'b0, 1'b0);

        // 16 hits wrap the timer; the 17th shifts: ages 010,100,000,000
        do_reset();
        access(4'b0001, 16);
        access(4'b0010, 1);
        do_search("wrap", 4'b0000, 2, 1'b0, 1'b0);
        do_search("wrap_lk", 4'b0100, 3, 1'b0, 1'b0);

        // hit+invalidate on way 0: age0 stays 0, timer still advances
        do_reset();
        access_en = 1'b1;
        hit_way   = 4'b0001;
        inv_en    = 1'b1;
        inv_way   = 4'b0001;
        @(negedge clk);
        inv_en    = 1'b0;
        inv_way   = 4'b0000;
        access(4'b0110, 1);
        do_search("inv_pri", 4'b0000, 0, 1'b0, 1'b0);
        do_search("inv_lk", 4'b0001, 3, 1'b0, 1'b0);
        // 14 more hits bring timer back to 0; shift gives 100,010,010,000
        access(4'b0010, 14);
        access(4'b0001, 1);
        do_search("inv_tmr", 4'b1000, 1, 1'b0, 1'b0);

        // reset two cycles into a search aborts it; hits overlapping reset are lost
        victim_req = 1'b1;
        @(negedge clk);
        victim_req = 1'b0;
        access_en  = 1'b1;
        hit_way    = 4'b0001;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        access_en = 1'b0;
        hit_way   = 4'b0000;
        chk("abort_busy", busy, 0);
        chk("abort_idx", victim_idx, 0);
        saw_valid = victim_valid;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            saw_valid = saw_valid | victim_valid;
        end
        chk("abort_novalid", saw_valid, 0);
        do_search("post_abort", 4'b0000, 0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
